npu_dma_reader: RTL and testbench
=================================

Name: npu_dma_reader

Overview:
Read-DMA engine that sits directly upstream of the shared memory's NPU port. It turns one configured transfer (source byte address, word count) into a sequence of single-word, non-burst read requests on the memory's NPU valid/ready interface. Returned 64-bit words are buffered in a small FIFO and presented to the NPU datapath as a valid/ready stream with a last-word marker.

Parameters:
FIFO_DEPTH, 8, entries of the output buffer; must be a power of two, at least 2.
LEN_W, 16, width of the transfer length field in 64-bit words.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_start  in  1  one-cycle pulse; starts a transfer; ignored unless idle
cfg_src_addr  in  64  source byte address; must be 8-byte aligned
cfg_len  in  LEN_W  number of 64-bit words to transfer
cfg_abort  in  1  one-cycle pulse; cancels the active transfer
busy  out  1  high from accepted start until done, error or aborted
done  out  1  one-cycle pulse when the last word is popped by the consumer
error  out  1  one-cycle pulse when a start is rejected
aborted  out  1  one-cycle pulse when abort completes
mem_valid  out  1  read request to the memory NPU port
mem_ready  in  1  one-cycle completion strobe from memory; read data valid in the same cycle
mem_address  out  64  byte address of the current word
mem_write_enable  out  1  tied 0
mem_byte_enable  out  8  tied 8'hFF
mem_write_data  out  64  tied 0
mem_burst_mode  out  1  tied 0
mem_burst_len  out  4  tied 0
mem_read_data  in  64  read data from memory
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the word
out_data  out  64  head-of-FIFO word
out_last  out  1  head word is the final word of the transfer

Behaviour:
- Reset values: busy=0, done=0, error=0, aborted=0, mem_valid=0, mem_address=0, out_valid=0, out_last=0. The FIFO is emptied and the state is IDLE.
- Asynchronous reset mid-transfer drops everything immediately; no done or aborted pulse is produced.
- States: IDLE, REQ, DRAIN, ABORT_WAIT.
- IDLE, on cfg_start:
  - If cfg_src_addr[2:0]!=0, pulse error next cycle and stay in IDLE.
  - Else if cfg_len==0, pulse done next cycle; busy stays 0.
  - Else latch the address and length, set words_left=cfg_len, set busy=1, and go to REQ.
- REQ, request issue:
  - The request register is set only when fifo_count < FIFO_DEPTH. At most one request is outstanding.
  - mem_valid = req_q AND NOT mem_ready, combinationally. This masking stops the memory from sampling a stale valid in the cycle its ready is visible.
  - On mem_ready while req_q is set: push mem_read_data into the FIFO, tagged last when words_left==1.
  - In the same cycle: clear req_q, add 8 to the address (64-bit wrap, no error), and decrement words_left.
  - The next request may be raised in the following cycle.
  - When words_left reaches 0, go to DRAIN.
- Simultaneous push and pop in the same cycle is legal; fifo_count is unchanged. A push is never attempted while the FIFO is full, which the credit check guarantees.
- DRAIN: on the out_valid && out_ready && out_last handshake, pulse done, clear busy and go to IDLE.
- cfg_abort in REQ or DRAIN:
  - If a request is outstanding, go to ABORT_WAIT, wait for mem_ready and discard the data.
  - Then flush the FIFO, pulse aborted, clear busy and go to IDLE.
  - Abort in IDLE is ignored. Abort has priority over a same-cycle done.
- cfg_start while busy is ignored and does not pulse error.
- The out_* stream follows AXI-stream rules: out_data and out_last are stable while out_valid && !out_ready.

Decomposition:
- Shared package npu_dma_pkg contains:
  - the state enum typedef dma_state_t (IDLE, REQ, DRAIN, ABORT_WAIT);
  - localparam WORD_BYTES=8;
  - the tie-off constants for byte enable and burst fields.
- One sub-module, npu_dma_fifo:
  - synchronous FIFO, width 65 (data plus last flag), depth FIFO_DEPTH;
  - ports push, pop, full, empty, count and flush.

Test Plan:
- Normal transfer: memory model with 2-cycle latency preloaded mem[i]=i*0x1111. start with src=0x40 and len=4, out_ready=1. Required: out_data 0x8888, 0x9999, 0xAAAA, 0xBBBB in order; out_last only on 0xBBBB; one done pulse; addresses 0x40, 0x48, 0x50, 0x58.
- Backpressure: len=12, FIFO_DEPTH=8, out_ready=0. Required: exactly 8 requests, then mem_valid stays 0. Raising out_ready then drains all 12 words in order with no duplicate or missing address.
- Rejects: src=0x44 gives one error pulse and no mem_valid. src=0x40 with len=0 gives one done pulse and busy stays 0.
- Abort: abort issued while the 3rd request is outstanding in a len=8 transfer. Required: the pending mem_ready is consumed, the FIFO is flushed, out_valid=0, one aborted pulse, no done pulse, and a new start then works.
- Reset mid-transfer: rst_n driven low for 1 cycle during REQ. Required: all outputs at reset values immediately; after release, mem_valid=0 until a new start.
- Handshake hygiene: the memory never sees mem_valid=1 in a cycle where mem_ready=1. Checked by assertion across all scenarios.

Source files
------------

// File: rtl/npu_dma_pkg.sv
// Shared types and constants for the NPU read-DMA engine.
package npu_dma_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        DRAIN      = 2'd2,
        ABORT_WAIT = 2'd3
    } dma_state_t;

    localparam int WORD_BYTES = 8;

    // The reader only ever issues full-word, single-beat reads.
    localparam logic [7:0] MEM_BYTE_EN_ALL    = 8'hFF;
    localparam logic       MEM_BURST_MODE_OFF = 1'b0;
    localparam logic [3:0] MEM_BURST_LEN_NONE = 4'd0;

endpackage

// File: rtl/npu_dma_reader_if.sv
// Shared-memory NPU port: valid/ready request with same-cycle read data.
interface npu_dma_reader_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_address;
    logic        mem_write_enable;
    logic [7:0]  mem_byte_enable;
    logic [63:0] mem_write_data;
    logic        mem_burst_mode;
    logic [3:0]  mem_burst_len;
    logic [63:0] mem_read_data;

    modport master (
        output mem_valid, mem_address, mem_write_enable, mem_byte_enable,
               mem_write_data, mem_burst_mode, mem_burst_len,
        input  mem_ready, mem_read_data
    );

    modport slave (
        input  mem_valid, mem_address, mem_write_enable, mem_byte_enable,
               mem_write_data, mem_burst_mode, mem_burst_len,
        output mem_ready, mem_read_data
    );

endinterface

// File: rtl/npu_dma_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
module npu_dma_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/npu_dma_reader.sv
// Read-DMA engine: walks an aligned source region one 64-bit read at a time
// and streams the returned words out through a credit-checked FIFO.
module npu_dma_reader
    import npu_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [63:0]      cfg_src_addr,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             aborted,
    npu_dma_reader_if.master mem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_t       state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic             req_q, req_d;
    logic             done_d, error_d, aborted_d;

    logic             fifo_push, fifo_pop, fifo_flush;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [64:0]      fifo_rd_data;

    logic             mem_done;
    logic             last_word;
    logic             last_pop;

    assign mem_done  = req_q && mem.mem_ready;
    assign last_word = (words_left_q == LEN_W'(1));
    assign last_pop  = out_valid && out_ready && out_last;
    assign busy      = (state_q != IDLE);

    // Valid is masked by ready so the memory never samples a completed request twice.
    assign mem.mem_valid        = req_q && !mem.mem_ready;
    assign mem.mem_address      = addr_q;
    assign mem.mem_write_enable = 1'b0;
    assign mem.mem_byte_enable  = MEM_BYTE_EN_ALL;
    assign mem.mem_write_data   = '0;
    assign mem.mem_burst_mode   = MEM_BURST_MODE_OFF;
    assign mem.mem_burst_len    = MEM_BURST_LEN_NONE;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data[63:0];
    assign out_last  = !fifo_empty && fifo_rd_data[64];
    assign fifo_pop  = out_valid && out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        req_d        = req_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        aborted_d    = 1'b0;
        fifo_push    = 1'b0;
        fifo_flush   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_src_addr[2:0] != 3'd0) begin
                        error_d = 1'b1;
                    end else if (cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d       = cfg_src_addr;
                        words_left_d = cfg_len;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (cfg_abort) begin
                    fifo_flush = 1'b1;
                    if (req_q && !mem.mem_ready) begin
                        state_d = ABORT_WAIT;
                    end else begin
                        req_d     = 1'b0;
                        aborted_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (mem_done) begin
                    fifo_push    = !fifo_full;
                    req_d        = 1'b0;
                    addr_d       = addr_q + 64'(WORD_BYTES);
                    words_left_d = words_left_q - 1'b1;
                    if (last_word) state_d = DRAIN;
                end else if (!req_q && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
                    req_d = 1'b1;
                end
            end
            DRAIN: begin
                if (cfg_abort) begin
                    fifo_flush = 1'b1;
                    aborted_d  = 1'b1;
                    state_d    = IDLE;
                end else if (last_pop) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ABORT_WAIT: begin
                // The outstanding read must still complete; its data is dropped.
                fifo_flush = 1'b1;
                if (mem.mem_ready) begin
                    req_d     = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            req_q        <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            req_q        <= req_d;
            done         <= done_d;
            error        <= error_d;
            aborted      <= aborted_d;
        end
    end

    npu_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (65)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data ({last_word, mem.mem_read_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_npu_dma_reader.sv
// Directed bench for npu_dma_reader with a 2-cycle-latency memory responder.
module tb_npu_dma_reader;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [63:0] cfg_src_addr;
    logic [15:0] cfg_len;
    logic        cfg_abort;
    logic        busy, done, error, aborted;
    logic        out_valid, out_ready, out_last;
    logic [63:0] out_data;

    int passed;
    int total;

    npu_dma_reader_if mem_if ();

    npu_dma_reader #(
        .FIFO_DEPTH (8),
        .LEN_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_src_addr (cfg_src_addr),
        .cfg_len      (cfg_len),
        .cfg_abort    (cfg_abort),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .aborted      (aborted),
        .mem          (mem_if),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: accepts a request, waits, then strobes ready for one cycle.
    logic [63:0] req_addrs [$];
    bit          mem_pend;
    int          mem_wait;
    logic [63:0] mem_pend_addr;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return (a >> 3) * 64'h1111;
    endfunction

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            mem_if.mem_ready     = 1'b0;
            mem_if.mem_read_data = '0;
            mem_pend             = 1'b0;
            mem_wait             = 0;
        end else if (mem_if.mem_ready) begin
            mem_if.mem_ready = 1'b0;
        end else if (mem_pend) begin
            if (mem_wait > 0) begin
                mem_wait--;
            end else begin
                mem_if.mem_ready     = 1'b1;
                mem_if.mem_read_data = mem_word(mem_pend_addr);
                mem_pend             = 1'b0;
            end
        end else if (mem_if.mem_valid) begin
            mem_pend      = 1'b1;
            mem_wait      = 1;
            mem_pend_addr = mem_if.mem_address;
            req_addrs.push_back(mem_if.mem_address);
        end
    end

    // Monitors sample mid-cycle, away from the active edge.
    int          done_cnt, error_cnt, aborted_cnt, valid_cycles, busy_cycles, hs_viol;
    logic [64:0] got [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (done)    done_cnt++;
            if (error)   error_cnt++;
            if (aborted) aborted_cnt++;
            if (busy)    busy_cycles++;
            if (mem_if.mem_valid) valid_cycles++;
            if (mem_if.mem_valid && mem_if.mem_ready) hs_viol++;
            if (out_valid && out_ready) got.push_back({out_last, out_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [63:0] a, input logic [15:0] l);
        cfg_src_addr = a;
        cfg_len      = l;
        cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %0b want 0", error); else passed++;
        total++; if (aborted !== 1'b0) $display("FAIL reset_aborted: got %0b want 0", aborted); else passed++;
        total++; if (mem_if.mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %0b want 0", mem_if.mem_valid); else passed++;
        total++; if (mem_if.mem_address !== 64'h0) $display("FAIL reset_mem_address: got %0h want 0", mem_if.mem_address); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b want 0", out_last); else passed++;
        total++; if (mem_if.mem_byte_enable !== 8'hFF) $display("FAIL tie_byte_enable: got %0h want ff", mem_if.mem_byte_enable); else passed++;
        total++; if ({mem_if.mem_write_enable, mem_if.mem_burst_mode, mem_if.mem_burst_len} !== 6'd0)
            $display("FAIL tie_write_burst: got %0h want 0", {mem_if.mem_write_enable, mem_if.mem_burst_mode, mem_if.mem_burst_len});
        else passed++;
        total++; if (mem_if.mem_write_data !== 64'h0) $display("FAIL tie_write_data: got %0h want 0", mem_if.mem_write_data); else passed++;
    endtask

    task automatic test_normal();
        logic [63:0] exp_data [4];
        int d0, e0, g0, r0, n;
        exp_data[0] = 64'h8888; exp_data[1] = 64'h9999;
        exp_data[2] = 64'hAAAA; exp_data[3] = 64'hBBBB;
        d0 = done_cnt; e0 = error_cnt; g0 = got.size(); r0 = req_addrs.size();
        out_ready = 1'b1;
        start_xfer(64'h40, 16'd4);
        // A misaligned start while busy must be ignored silently.
        start_xfer(64'h44, 16'd4);
        n = 0;
        while (done_cnt == d0 && n < 300) begin tick(); n++; end
        total++; if (n >= 300) $display("FAIL normal_timeout: no done after %0d cycles", n); else passed++;
        repeat (3) tick();
        total++; if (got.size() - g0 != 4) $display("FAIL normal_count: got %0d words want 4", got.size() - g0); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got.size() <= g0 + i || got[g0 + i] !== {(i == 3), exp_data[i]})
                $display("FAIL normal_word%0d: got %0h want %0h", i,
                         (got.size() > g0 + i) ? got[g0 + i] : 65'h0, {(i == 3), exp_data[i]});
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (req_addrs.size() <= r0 + i || req_addrs[r0 + i] !== 64'h40 + 64'(8 * i))
                $display("FAIL normal_addr%0d: got %0h want %0h", i,
                         (req_addrs.size() > r0 + i) ? req_addrs[r0 + i] : 64'h0, 64'h40 + 64'(8 * i));
            else passed++;
        end
        total++; if (req_addrs.size() - r0 != 4) $display("FAIL normal_req_count: got %0d want 4", req_addrs.size() - r0); else passed++;
        total++; if (done_cnt - d0 != 1) $display("FAIL normal_done_pulses: got %0d want 1", done_cnt - d0); else passed++;
        total++; if (error_cnt - e0 != 0) $display("FAIL busy_start_error: got %0d want 0", error_cnt - e0); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL normal_busy_end: got %0b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        int d0, g0, r0, n, r8;
        d0 = done_cnt; g0 = got.size(); r0 = req_addrs.size();
        out_ready = 1'b0;
        start_xfer(64'h40, 16'd12);
        n = 0;
        while (req_addrs.size() - r0 < 8 && n < 300) begin tick(); n++; end
        repeat (30) tick();
        r8 = req_addrs.size() - r0;
        total++; if (r8 != 8) $display("FAIL bp_req_count: got %0d want 8", r8); else passed++;
        total++; if (mem_if.mem_valid !== 1'b0) $display("FAIL bp_mem_valid: got %0b want 0", mem_if.mem_valid); else passed++;
        total++; if ({out_valid, out_data} !== {1'b1, 64'h8888}) $display("FAIL bp_head: got %0h want 18888", {out_valid, out_data}); else passed++;
        out_ready = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 500) begin tick(); n++; end
        total++; if (n >= 500) $display("FAIL bp_timeout: no done after %0d cycles", n); else passed++;
        repeat (3) tick();
        total++; if (got.size() - g0 != 12) $display("FAIL bp_word_count: got %0d want 12", got.size() - g0); else passed++;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (got.size() <= g0 + i || got[g0 + i] !== {(i == 11), 64'((8 + i) * 'h1111)})
                $display("FAIL bp_word%0d: got %0h want %0h", i,
                         (got.size() > g0 + i) ? got[g0 + i] : 65'h0, {(i == 11), 64'((8 + i) * 'h1111)});
            else passed++;
        end
        total++; if (req_addrs.size() - r0 != 12) $display("FAIL bp_addr_count: got %0d want 12", req_addrs.size() - r0); else passed++;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (req_addrs.size() <= r0 + i || req_addrs[r0 + i] !== 64'h40 + 64'(8 * i))
                $display("FAIL bp_addr%0d: got %0h want %0h", i,
                         (req_addrs.size() > r0 + i) ? req_addrs[r0 + i] : 64'h0, 64'h40 + 64'(8 * i));
            else passed++;
        end
        total++; if (done_cnt - d0 != 1) $display("FAIL bp_done_pulses: got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_rejects();
        int e0, d0, v0, b0;
        e0 = error_cnt; d0 = done_cnt; v0 = valid_cycles; b0 = busy_cycles;
        out_ready = 1'b1;
        start_xfer(64'h44, 16'd4);
        repeat (4) tick();
        total++; if (error_cnt - e0 != 1) $display("FAIL misaligned_error: got %0d pulses want 1", error_cnt - e0); else passed++;
        total++; if (valid_cycles - v0 != 0) $display("FAIL misaligned_mem_valid: got %0d cycles want 0", valid_cycles - v0); else passed++;
        total++; if (busy_cycles - b0 != 0) $display("FAIL misaligned_busy: got %0d cycles want 0", busy_cycles - b0); else passed++;
        start_xfer(64'h40, 16'd0);
        repeat (4) tick();
        total++; if (done_cnt - d0 != 1) $display("FAIL zero_len_done: got %0d pulses want 1", done_cnt - d0); else passed++;
        total++; if (busy_cycles - b0 != 0) $display("FAIL zero_len_busy: got %0d cycles want 0", busy_cycles - b0); else passed++;
        total++; if (valid_cycles - v0 != 0) $display("FAIL zero_len_mem_valid: got %0d cycles want 0", valid_cycles - v0); else passed++;
        total++; if (error_cnt - e0 != 1) $display("FAIL zero_len_error: got %0d pulses want 1", error_cnt - e0); else passed++;
    endtask

    task automatic test_abort();
        int a0, d0, g0, r0, n;
        a0 = aborted_cnt; d0 = done_cnt; g0 = got.size(); r0 = req_addrs.size();
        out_ready = 1'b0;
        start_xfer(64'h80, 16'd8);
        n = 0;
        while (req_addrs.size() - r0 < 3 && n < 200) begin tick(); n++; end
        total++; if (mem_if.mem_valid !== 1'b1) $display("FAIL abort_third_pending: got %0b want 1", mem_if.mem_valid); else passed++;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        total++; if (n >= 50) $display("FAIL abort_timeout: still busy after %0d cycles", n); else passed++;
        repeat (5) tick();
        total++; if (aborted_cnt - a0 != 1) $display("FAIL abort_pulses: got %0d want 1", aborted_cnt - a0); else passed++;
        total++; if (done_cnt - d0 != 0) $display("FAIL abort_done: got %0d want 0", done_cnt - d0); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %0b want 0", out_valid); else passed++;
        total++; if (req_addrs.size() - r0 != 3) $display("FAIL abort_req_count: got %0d want 3", req_addrs.size() - r0); else passed++;
        total++; if ({mem_pend, mem_if.mem_valid} !== 2'b00) $display("FAIL abort_pending_consumed: got %0b want 0", {mem_pend, mem_if.mem_valid}); else passed++;
        total++; if (got.size() - g0 != 0) $display("FAIL abort_words_out: got %0d want 0", got.size() - g0); else passed++;

        out_ready = 1'b1;
        start_xfer(64'h100, 16'd2);
        n = 0;
        while (done_cnt == d0 && n < 200) begin tick(); n++; end
        total++; if (n >= 200) $display("FAIL restart_timeout: no done after %0d cycles", n); else passed++;
        repeat (2) tick();
        total++; if (got.size() - g0 != 2) $display("FAIL restart_count: got %0d want 2", got.size() - g0); else passed++;
        total++; if (got.size() < g0 + 2 || got[g0] !== {1'b0, 64'h22220} || got[g0 + 1] !== {1'b1, 64'h23331})
            $display("FAIL restart_words: got %0h %0h want 022220 123331",
                     (got.size() > g0) ? got[g0] : 65'h0, (got.size() > g0 + 1) ? got[g0 + 1] : 65'h0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int d0, a0, r0, v0, n;
        d0 = done_cnt; a0 = aborted_cnt; r0 = req_addrs.size();
        out_ready = 1'b0;
        start_xfer(64'h200, 16'd8);
        n = 0;
        while (req_addrs.size() - r0 < 2 && n < 200) begin tick(); n++; end
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, error, aborted} !== 4'b0) $display("FAIL midrst_status: got %0b want 0", {busy, done, error, aborted}); else passed++;
        total++; if (mem_if.mem_valid !== 1'b0) $display("FAIL midrst_mem_valid: got %0b want 0", mem_if.mem_valid); else passed++;
        total++; if (mem_if.mem_address !== 64'h0) $display("FAIL midrst_mem_address: got %0h want 0", mem_if.mem_address); else passed++;
        total++; if ({out_valid, out_last} !== 2'b00) $display("FAIL midrst_out: got %0b want 0", {out_valid, out_last}); else passed++;
        tick();
        rst_n = 1'b1;
        v0 = valid_cycles;
        repeat (12) tick();
        total++; if (valid_cycles - v0 != 0) $display("FAIL midrst_mem_valid_after: got %0d cycles want 0", valid_cycles - v0); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy_after: got %0b want 0", busy); else passed++;
        total++; if ((done_cnt - d0) + (aborted_cnt - a0) != 0)
            $display("FAIL midrst_pulses: got %0d want 0", (done_cnt - d0) + (aborted_cnt - a0));
        else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rst_n        = 1'b0;
        cfg_start    = 1'b0;
        cfg_src_addr = '0;
        cfg_len      = '0;
        cfg_abort    = 1'b0;
        out_ready    = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        repeat (2) tick();

        test_normal();
        test_backpressure();
        test_rejects();
        test_abort();
        test_reset_mid();

        total++; if (hs_viol != 0) $display("FAIL handshake_hygiene: got %0d valid&ready cycles want 0", hs_viol); else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
